// File: rtl/ingress_voq_pkg.sv
// Shared switch definitions: default port count, destination field position and packet word types.
package ingress_voq_pkg;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned NUM_PORTS_DEF = 4;
  localparam int unsigned PORT_W        = $clog2(NUM_PORTS_DEF);
  localparam int unsigned DEST_LSB_DEF  = WORD_W - PORT_W;
  localparam int unsigned DROP_CNT_W    = 16;

  typedef logic [PORT_W-1:0] port_idx_t;

  typedef struct packed {
    port_idx_t                  dest;
    logic [WORD_W-PORT_W-1:0]   payload;
  } packet_t;
endpackage

// File: rtl/ingress_voq_if.sv
// Packet-in / scheduler-side bundle of the ingress VOQ; master drives words and dequeues.
interface ingress_voq_if
  import ingress_voq_pkg::*;
#(
  parameter int unsigned NUM_PORTS = NUM_PORTS_DEF
);
  logic                           in_valid;
  packet_t                        in_data;
  logic                           deq_en;
  logic [$clog2(NUM_PORTS)-1:0]   deq_port;
  logic [NUM_PORTS-1:0]           voq_req;
  logic [NUM_PORTS-1:0]           voq_full;
  logic                           deq_valid;
  packet_t                        deq_data;
  logic [DROP_CNT_W-1:0]          drop_count;

  modport master (
    output in_valid, in_data, deq_en, deq_port,
    input  voq_req, voq_full, deq_valid, deq_data, drop_count
  );

  modport slave (
    input  in_valid, in_data, deq_en, deq_port,
    output voq_req, voq_full, deq_valid, deq_data, drop_count
  );
endinterface

// File: rtl/ingress_voq_fifo.sv
// Single circular per-destination queue; a write into a full queue is accepted only alongside a read.
module ingress_voq_fifo
  import ingress_voq_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    wr_en,
  input  packet_t wr_data,
  input  logic    rd_en,
  output packet_t head_c,
  output logic    rd_ok_c,
  output logic    full,
  output logic    empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  packet_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             wr_ok;

  assign rd_ok_c = rd_en && !empty_q;
  assign wr_ok   = wr_en && (!full_q || rd_ok_c);
  assign head_c  = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok)   wr_ptr_d = PTR_W'(wr_ptr_q + PTR_W'(1));
    if (rd_ok_c) rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(1));
    case ({wr_ok, rd_ok_c})
      2'b10:   count_d = CNT_W'(count_q + CNT_W'(1));
      2'b01:   count_d = CNT_W'(count_q - CNT_W'(1));
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == CNT_W'(0));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage is left unreset; contents behind an empty count are never observed.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/ingress_voq.sv
// Ingress virtual-output-queue buffer: steers packet words into per-destination queues, serves scheduler dequeues.
// Optional saturating drop counter built only when INGRESS_VOQ_DROP_CNT_EN is defined.
module ingress_voq
  import ingress_voq_pkg::*;
#(
  parameter int unsigned NUM_PORTS = NUM_PORTS_DEF,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DEST_LSB  = DEST_LSB_DEF
) (
  input  logic         clk,
  input  logic         reset,
  ingress_voq_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(NUM_PORTS);

  logic [SEL_W-1:0]     dest;
  logic [NUM_PORTS-1:0] wr_en, rd_en, rd_ok_c, full, empty;
  packet_t              head_c [NUM_PORTS];
  logic                 deq_valid_q, deq_valid_d;
  packet_t              deq_data_q, deq_data_d;

  assign dest = bus.in_data[DEST_LSB +: SEL_W];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_q
    assign wr_en[i] = bus.in_valid && (dest == SEL_W'(i));
    assign rd_en[i] = bus.deq_en && (bus.deq_port == SEL_W'(i));

    ingress_voq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en[i]),
      .wr_data (bus.in_data),
      .rd_en   (rd_en[i]),
      .head_c  (head_c[i]),
      .rd_ok_c (rd_ok_c[i]),
      .full    (full[i]),
      .empty   (empty[i])
    );
  end

  // Dequeue output register: data holds its last value when nothing is popped.
  always_comb begin
    deq_valid_d = |rd_ok_c;
    deq_data_d  = deq_data_q;
    if (|rd_ok_c) deq_data_d = head_c[bus.deq_port];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deq_valid_q <= 1'b0;
      deq_data_q  <= '0;
    end else begin
      deq_valid_q <= deq_valid_d;
      deq_data_q  <= deq_data_d;
    end
  end

  assign bus.voq_req   = ~empty;
  assign bus.voq_full  = full;
  assign bus.deq_valid = deq_valid_q;
  assign bus.deq_data  = deq_data_q;

`ifdef INGRESS_VOQ_DROP_CNT_EN
  logic                  drop_c;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // A full target only drops when it is not being popped in the same cycle.
  assign drop_c = bus.in_valid && full[dest] && !rd_ok_c[dest];

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_c && (drop_cnt_q != {DROP_CNT_W{1'b1}}))
      drop_cnt_d = DROP_CNT_W'(drop_cnt_q + DROP_CNT_W'(1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign bus.drop_count = drop_cnt_q;
`else
  assign bus.drop_count = '0;
`endif
endmodule

// File: tb/tb_ingress_voq.sv
// Directed self-checking bench for ingress_voq (NUM_PORTS=4, DEPTH=8, DEST_LSB=30).
module tb_ingress_voq;
  import ingress_voq_pkg::*;

`ifdef INGRESS_VOQ_DROP_CNT_EN
  localparam logic [31:0] EXP_DROP1 = 32'd1;
`else
  localparam logic [31:0] EXP_DROP1 = 32'd0;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  ingress_voq_if #(.NUM_PORTS(4)) bus ();

  ingress_voq #(.NUM_PORTS(4), .DEPTH(8), .DEST_LSB(30)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.deq_en   = 1'b0;
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.deq_en   = 1'b0;
    bus.deq_port = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();

    check("rst_req",   32'(bus.voq_req),   32'h0);
    check("rst_full",  32'(bus.voq_full),  32'h0);
    check("rst_valid", 32'(bus.deq_valid), 32'h0);
    check("rst_drop",  32'(bus.drop_count), 32'h0);

    // Single word through queue 1
    bus.in_valid = 1'b1; bus.in_data = 32'h4000_0011;
    tick();
    idle();
    check("q1_req", 32'(bus.voq_req), 32'h2);
    bus.deq_en = 1'b1; bus.deq_port = 2'd1;
    tick();
    idle();
    check("q1_valid", 32'(bus.deq_valid), 32'h1);
    check("q1_data",  32'(bus.deq_data),  32'h4000_0011);
    check("q1_req0",  32'(bus.voq_req),   32'h0);
    tick();
    check("q1_pulse", 32'(bus.deq_valid), 32'h0);

    // Overfill queue 3: ninth word is dropped
    for (int k = 1; k <= 9; k++) begin
      bus.in_valid = 1'b1; bus.in_data = 32'hC000_0000 | 32'(k);
      tick();
      if (k == 8) check("q3_full8", 32'(bus.voq_full), 32'h8);
    end
    idle();
    check("q3_full9", 32'(bus.voq_full),   32'h8);
    check("q3_drop",  32'(bus.drop_count), EXP_DROP1);
    for (int k = 1; k <= 8; k++) begin
      bus.deq_en = 1'b1; bus.deq_port = 2'd3;
      tick();
      check("q3_valid", 32'(bus.deq_valid), 32'h1);
      check("q3_data",  32'(bus.deq_data),  32'hC000_0000 | 32'(k));
    end
    idle();
    tick();
    check("q3_idle", 32'(bus.deq_valid), 32'h0);
    check("q3_req",  32'(bus.voq_req),   32'h0);

    // Full queue 2: simultaneous enqueue and dequeue
    for (int k = 0; k < 8; k++) begin
      bus.in_valid = 1'b1; bus.in_data = 32'h8000_0100 | 32'(k);
      tick();
    end
    check("q2_full", 32'(bus.voq_full), 32'h4);
    bus.in_valid = 1'b1; bus.in_data = 32'h8000_01FF;
    bus.deq_en   = 1'b1; bus.deq_port = 2'd2;
    tick();
    idle();
    check("q2_valid", 32'(bus.deq_valid),  32'h1);
    check("q2_data",  32'(bus.deq_data),   32'h8000_0100);
    check("q2_still", 32'(bus.voq_full),   32'h4);
    check("q2_nodrop", 32'(bus.drop_count), EXP_DROP1);
    for (int k = 1; k <= 8; k++) begin
      bus.deq_en = 1'b1; bus.deq_port = 2'd2;
      tick();
      check("q2_drain", 32'(bus.deq_data), (k == 8) ? 32'h8000_01FF : (32'h8000_0100 | 32'(k)));
    end
    idle();
    tick();
    check("q2_empty", 32'(bus.voq_req), 32'h0);

    // Empty queue 0: enqueue and dequeue together, no bypass
    bus.in_valid = 1'b1; bus.in_data = 32'h0000_0055;
    bus.deq_en   = 1'b1; bus.deq_port = 2'd0;
    tick();
    idle();
    check("q0_novalid", 32'(bus.deq_valid), 32'h0);
    check("q0_hold",    32'(bus.deq_data),  32'h8000_01FF);
    check("q0_req",     32'(bus.voq_req),   32'h1);
    bus.deq_en = 1'b1; bus.deq_port = 2'd0;
    tick();
    idle();
    check("q0_valid", 32'(bus.deq_valid), 32'h1);
    check("q0_data",  32'(bus.deq_data),  32'h0000_0055);

    // Mid-stream asynchronous reset
    bus.in_valid = 1'b1; bus.in_data = 32'h0000_0001; tick();
    bus.in_data = 32'h0000_0002; tick();
    bus.in_data = 32'h4000_0003; tick();
    bus.in_data = 32'h0000_0004;
    bus.deq_en = 1'b1; bus.deq_port = 2'd0;
    tick();
    check("pre_rst_valid", 32'(bus.deq_valid), 32'h1);
    check("pre_rst_req",   32'(bus.voq_req),   32'h3);
    #2 reset = 1'b0;
    #1;
    check("arst_req",   32'(bus.voq_req),   32'h0);
    check("arst_full",  32'(bus.voq_full),  32'h0);
    check("arst_valid", 32'(bus.deq_valid), 32'h0);
    check("arst_data",  32'(bus.deq_data),  32'h0);
    check("arst_drop",  32'(bus.drop_count), 32'h0);
    tick();
    check("in_rst_req", 32'(bus.voq_req), 32'h0);
    idle();
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("post_req",   32'(bus.voq_req),   32'h0);
    check("post_valid", 32'(bus.deq_valid), 32'h0);
    bus.deq_en = 1'b1; bus.deq_port = 2'd0;
    tick();
    idle();
    check("post_deq", 32'(bus.deq_valid), 32'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
